// File: rtl/arb_rr_tree.sv
// arb_rr_tree: registered round-robin arbiter with rotating mask over two priority trees.
// Rev 1.0
`default_nettype none

module arb_rr_tree_cell #(
  parameter int    SPLIT          = 2,
  parameter string DIRECTION      = "LSB",
  parameter int    IMPLEMENTATION = 0
) (
  input  logic [SPLIT-1:0] in,
  output logic [SPLIT-1:0] oh,
  output logic             any
);
  localparam bit IS_MSB = (DIRECTION == "MSB");

  logic [SPLIT-1:0] rin;
  logic [SPLIT-1:0] roh;

  // MSB priority is handled by mirroring, so both cell styles only search upward.
  always_comb begin
    rin = '0;
    for (int i = 0; i < SPLIT; i++) begin
      rin[i] = IS_MSB ? in[SPLIT-1-i] : in[i];
    end
  end

  if (IMPLEMENTATION == 1) begin : g_arith
    assign roh = rin & (~rin + SPLIT'(1));
  end else begin : g_scan
    logic found;
    always_comb begin
      roh   = '0;
      found = 1'b0;
      for (int i = 0; i < SPLIT; i++) begin
        if (rin[i] && !found) begin
          roh[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    oh = '0;
    for (int i = 0; i < SPLIT; i++) begin
      oh[i] = IS_MSB ? roh[SPLIT-1-i] : roh[i];
    end
  end

  assign any = |in;
endmodule

module arb_rr_tree_prio #(
  parameter int    WIDTH          = 32,
  parameter int    SPLIT          = 2,
  parameter string DIRECTION      = "LSB",
  parameter int    IMPLEMENTATION = 0
) (
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] oh,
  output logic             any
);
  function automatic int log_split(input int w, input int s);
    int x;
    int n;
    x = w;
    n = 0;
    while (s > 1 && x > 1 && (x % s) == 0) begin
      x = x / s;
      n = n + 1;
    end
    return (x == 1) ? n : 0;
  endfunction

  function automatic int node_cnt(input int lvl);
    int n;
    n = WIDTH;
    for (int j = 0; j < lvl; j++) n = n / SPLIT;
    return n;
  endfunction

  localparam int LEVELS = log_split(WIDTH, SPLIT);

  if (LEVELS >= 1) begin : g_ok
    // Valids fold upward level by level; selections fan back down gated by the parent.
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
      localparam int N  = node_cnt(l);
      localparam int NG = N / SPLIT;

      logic [N-1:0]  v;
      logic [N-1:0]  s;
      logic [N-1:0]  oh_all;
      logic [NG-1:0] up;
      logic [NG-1:0] s_up;

      if (l == 0) begin : g_leaf
        assign v = in;
      end else begin : g_inner
        assign v = g_lvl[l-1].up;
      end

      if (l == LEVELS - 1) begin : g_root
        assign s_up = up;
      end else begin : g_mid
        assign s_up = g_lvl[l+1].s;
      end

      for (genvar g = 0; g < NG; g++) begin : g_grp
        arb_rr_tree_cell #(
          .SPLIT          (SPLIT),
          .DIRECTION      (DIRECTION),
          .IMPLEMENTATION (IMPLEMENTATION)
        ) u_cell (
          .in  (v[g*SPLIT +: SPLIT]),
          .oh  (oh_all[g*SPLIT +: SPLIT]),
          .any (up[g])
        );
        assign s[g*SPLIT +: SPLIT] = oh_all[g*SPLIT +: SPLIT] & {SPLIT{s_up[g]}};
      end
    end

    assign oh  = g_lvl[0].s;
    assign any = g_lvl[LEVELS-1].up[0];
  end else begin : g_bad_width
    $error("arb_rr_tree: WIDTH must equal SPLIT**k with k >= 1");
    assign oh  = '0;
    assign any = 1'b0;
  end
endmodule

module arb_rr_tree #(
  parameter int    WIDTH          = 32,
  parameter int    SPLIT          = 2,
  parameter string DIRECTION      = "LSB",
  parameter int    IMPLEMENTATION = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req,
  input  logic             ack,
  output logic [WIDTH-1:0] gnt,
  output logic             vld
);
  localparam bit       IS_MSB      = (DIRECTION == "MSB");
  localparam logic [0:0] STATE_IDLE  = 1'b0;
  localparam logic [0:0] STATE_GRANT = 1'b1;

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [WIDTH-1:0] msk;
  logic [WIDTH-1:0] msk_nxt;
  logic [WIDTH-1:0] gnt_nxt;
  logic [WIDTH-1:0] above_gnt;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] sel_m;
  logic [WIDTH-1:0] sel_u;
  logic [WIDTH-1:0] sel;
  logic             vld_m;
  logic             any_u;
  logic             seen;

  // Bits strictly past the current winner in the search direction.
  always_comb begin
    above_gnt = '0;
    seen      = 1'b0;
    if (IS_MSB) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        above_gnt[i] = seen;
        seen         = seen | gnt[i];
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        above_gnt[i] = seen;
        seen         = seen | gnt[i];
      end
    end
  end

  assign m = (state == STATE_GRANT) ? above_gnt : msk;

  arb_rr_tree_prio #(
    .WIDTH          (WIDTH),
    .SPLIT          (SPLIT),
    .DIRECTION      (DIRECTION),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_tree_masked (
    .in  (req & m),
    .oh  (sel_m),
    .any (vld_m)
  );

  arb_rr_tree_prio #(
    .WIDTH          (WIDTH),
    .SPLIT          (SPLIT),
    .DIRECTION      (DIRECTION),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_tree_unmasked (
    .in  (req),
    .oh  (sel_u),
    .any (any_u)
  );

  assign sel = vld_m ? sel_m : sel_u;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= STATE_IDLE;
      gnt   <= '0;
      msk   <= '1;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      msk   <= msk_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    msk_nxt   = msk;
    case (state)
      STATE_IDLE: begin
        if (any_u) begin
          gnt_nxt   = sel;
          state_nxt = STATE_GRANT;
        end
      end
      STATE_GRANT: begin
        if (ack) begin
          msk_nxt = above_gnt;
          if (any_u) begin
            gnt_nxt = sel;
          end else begin
            gnt_nxt   = '0;
            state_nxt = STATE_IDLE;
          end
        end
      end
      default: begin
        state_nxt = STATE_IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    vld = (state == STATE_GRANT);
  end
endmodule

`default_nettype wire

// File: tb/tb_arb_rr_tree.sv
// tb_arb_rr_tree: directed vector bench for arb_rr_tree (LSB and MSB instances, WIDTH=8).
// Rev 1.0
`default_nettype none

module tb_arb_rr_tree;
  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic       ack;
    logic [7:0] gnt;
    logic       vld;
  } vec_t;

  logic       clk;
  logic       rst_n_l, ack_l, vld_l;
  logic [7:0] req_l, gnt_l;
  logic       rst_n_m, ack_m, vld_m;
  logic [7:0] req_m, gnt_m;

  int n_cmp;
  int n_bad;

  vec_t tbl [22];

  arb_rr_tree #(
    .WIDTH(8), .SPLIT(2), .DIRECTION("LSB"), .IMPLEMENTATION(0)
  ) u_lsb (
    .clk(clk), .rst_n(rst_n_l), .req(req_l), .ack(ack_l), .gnt(gnt_l), .vld(vld_l)
  );

  arb_rr_tree #(
    .WIDTH(8), .SPLIT(2), .DIRECTION("MSB"), .IMPLEMENTATION(1)
  ) u_msb (
    .clk(clk), .rst_n(rst_n_m), .req(req_m), .ack(ack_m), .gnt(gnt_m), .vld(vld_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic step_m(input logic r, input logic [7:0] q, input logic a,
                        input logic [7:0] eg, input logic ev, input string name);
    rst_n_m = r;
    req_m   = q;
    ack_m   = a;
    @(posedge clk);
    #1;
    check({name, ".gnt"}, gnt_m, eg);
    check({name, ".vld"}, {7'd0, vld_m}, {7'd0, ev});
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst_n_l = 1'b0; req_l = 8'h00; ack_l = 1'b0;
    rst_n_m = 1'b0; req_m = 8'h00; ack_m = 1'b0;

    //         rst_n  req    ack   gnt    vld
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[3]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[4]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[5]  = '{1'b1, 8'h24, 1'b0, 8'h04, 1'b1};
    tbl[6]  = '{1'b1, 8'h24, 1'b1, 8'h20, 1'b1};
    tbl[7]  = '{1'b1, 8'h24, 1'b1, 8'h04, 1'b1};
    tbl[8]  = '{1'b1, 8'h01, 1'b0, 8'h04, 1'b1};
    tbl[9]  = '{1'b1, 8'h00, 1'b0, 8'h04, 1'b1};
    tbl[10] = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b0};
    tbl[11] = '{1'b1, 8'h09, 1'b0, 8'h08, 1'b1};
    tbl[12] = '{1'b1, 8'h09, 1'b1, 8'h01, 1'b1};
    tbl[13] = '{1'b1, 8'h24, 1'b1, 8'h04, 1'b1};
    tbl[14] = '{1'b1, 8'h24, 1'b1, 8'h20, 1'b1};
    tbl[15] = '{1'b0, 8'h24, 1'b1, 8'h00, 1'b0};
    tbl[16] = '{1'b1, 8'h06, 1'b0, 8'h02, 1'b1};
    tbl[17] = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b0};
    tbl[18] = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b0};
    tbl[19] = '{1'b1, 8'h83, 1'b0, 8'h80, 1'b1};
    tbl[20] = '{1'b1, 8'h80, 1'b1, 8'h80, 1'b1};
    tbl[21] = '{1'b1, 8'h03, 1'b1, 8'h01, 1'b1};

    for (int i = 0; i < 22; i++) begin
      rst_n_l = tbl[i].rst_n;
      req_l   = tbl[i].req;
      ack_l   = tbl[i].ack;
      @(posedge clk);
      #1;
      check($sformatf("lsb[%0d].gnt", i), gnt_l, tbl[i].gnt);
      check($sformatf("lsb[%0d].vld", i), {7'd0, vld_l}, {7'd0, tbl[i].vld});
    end

    // Back-to-back throughput: all requesters pending, ack held.
    rst_n_l = 1'b0; req_l = 8'h00; ack_l = 1'b0;
    @(posedge clk);
    #1;
    rst_n_l = 1'b1; req_l = 8'hFF; ack_l = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [7:0] exp_g;
      exp_g = 8'h01 << (i % 8);
      @(posedge clk);
      #1;
      check($sformatf("lsb_tput[%0d].gnt", i), gnt_l, exp_g);
    end

    // Mirrored direction, run after the LSB instance is done.
    step_m(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, "msb_rst0");
    step_m(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, "msb_rst1");
    step_m(1'b1, 8'h81, 1'b0, 8'h80, 1'b1, "msb_first");
    step_m(1'b1, 8'h81, 1'b1, 8'h01, 1'b1, "msb_rot0");
    step_m(1'b1, 8'h81, 1'b1, 8'h80, 1'b1, "msb_wrap");
    step_m(1'b1, 8'h81, 1'b1, 8'h01, 1'b1, "msb_rot1");
    step_m(1'b1, 8'h10, 1'b1, 8'h10, 1'b1, "msb_single0");
    step_m(1'b1, 8'h10, 1'b1, 8'h10, 1'b1, "msb_single1");
    step_m(1'b1, 8'h10, 1'b1, 8'h10, 1'b1, "msb_single2");
    step_m(1'b1, 8'h00, 1'b1, 8'h00, 1'b0, "msb_drain");
    // msk now holds bits below 4; 0x24 picks bit 2 first.
    step_m(1'b1, 8'h24, 1'b0, 8'h04, 1'b1, "msb_ptr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/arb_rr_tree.md
# arb_rr_tree

Registered round-robin arbiter built on the priority-to-one-hot tree. It adds a rotating priority pointer, a grant/acknowledge handshake and registered outputs. It sits in front of shared resources (buses, FIFOs, memory ports): it picks one of `WIDTH` requesters and holds the grant until it is acknowledged. The next search then starts just past the last winner.

## Interface
Parameters:
- `WIDTH`, 32, number of requesters; must equal `SPLIT`**k, k ≥ 1 (elaboration-time assertion).
- `SPLIT`, 2, tree branching factor passed to both internal priority trees.
- `DIRECTION`, "LSB", "LSB": priority rotates upward from bit 0. "MSB": mirrored, rotates downward from bit `WIDTH-1`.
- `IMPLEMENTATION`, 0, passed unchanged to the priority-tree leaf/branch cells.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  reset; one clock, synchronous, active-low.
- `req`  input  `WIDTH`  request vector; one bit per requester.
- `ack`  input  1  grant accepted by downstream; only meaningful while `vld`=1.
- `gnt`  output  `WIDTH`  registered one-hot grant; all zeros when `vld`=0.
- `vld`  output  1  registered; a grant is present on `gnt`.

## Operation
- State: `gnt`, `vld` and mask register `msk[WIDTH]`.
- Two priority trees, both using `DIRECTION`:
  - masked tree on `req & m`;
  - unmasked tree on `req`.
- Selection: masked tree result if its valid is set, else unmasked tree result. The combined valid is `|req`.
- Effective mask `m`:
  - when `vld`=0, `m = msk`;
  - when `vld`=1, `m = above(gnt)`.
  - LSB: `above(g)` = all bits with index strictly greater than the set bit of `g`.
  - MSB: all bits with index strictly less than the set bit of `g`.
- IDLE (`vld`=0):
  - `|req`=1: load `gnt` with the selection and set `vld`=1; go to GRANT.
  - `|req`=0: stay in IDLE.
  - `msk` is unchanged.
- GRANT (`vld`=1, `ack`=0): `gnt`, `vld` and `msk` hold.
  - `req` is ignored, including deassertion of the granted bit. Requesters keep `req` high until acknowledged.
- GRANT with `ack`=1:
  - `msk <= above(gnt)`.
  - If `|req`=1, load `gnt` with the selection made under `m = above(gnt)` and stay in GRANT. The acknowledged requester may win again only if no other bit is set.
  - If `|req`=0, go to IDLE with `gnt=0`, `vld=0`.
- Wrap-around: when the masked request is empty, the unmasked tree restarts from the lowest bit (LSB) or highest bit (MSB).
- `ack` while `vld`=0 is ignored.
- Invariant: `gnt` is zero or exactly one-hot, and `gnt` is nonzero iff `vld`=1.

## Timing
- Reset (`rst_n`=0 at a rising edge): `gnt=0`, `vld=0`, `msk` = all ones, which gives plain priority order after reset.
- Reset overrides any state, including mid-grant with `ack`=1.
- Latency: request visible at edge N gives grant at edge N+1. There is no combinational path from `req` or `ack` to the outputs.
- Throughput: one grant per cycle with `ack` held high and requests pending. There are no bubble cycles between consecutive grants.
- Critical path: the mask from `gnt`, the tree depth log_SPLIT(WIDTH) levels, and a 2:1 select into the `gnt` register.

## Test plan
WIDTH=8, SPLIT=2, DIRECTION="LSB" unless stated.
- Reset and idle: hold `rst_n`=0 for 2 cycles, then `req`=0x00 for 3 cycles -> `gnt`=0x00 and `vld`=0 every cycle.
- Rotation and wrap:
  - `req`=0x24 from idle -> next cycle `gnt`=0x04, `vld`=1.
  - With `ack`=1 -> `gnt`=0x20, then `gnt`=0x04.
  - One grant per cycle, no gaps.
- Hold without ack: in state `gnt`=0x04, keep `ack`=0 and change `req` to 0x01, then 0x00 -> `gnt` stays 0x04, `vld`=1 for all cycles.
- Drain and pointer memory:
  - At `gnt`=0x04, `ack`=1 with `req`=0x00 -> `vld`=0, `gnt`=0, `msk`=0xF8.
  - Then `req`=0x09 -> `gnt`=0x08.
  - Then `ack`=1 with `req`=0x09 -> `gnt`=0x01.
- Reset mid-operation: with `vld`=1, `gnt`=0x20, drive `rst_n`=0 and `ack`=1 -> next edge `gnt`=0, `vld`=0. Then `req`=0x06 -> `gnt`=0x02 (mask back to all ones).
- MSB direction (DIRECTION="MSB"): `req`=0x81 with `ack`=1 -> `gnt` sequence 0x80, 0x01, 0x80. With a single requester, `req`=0x10 -> `gnt`=0x10 on every acknowledged cycle.
